// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: MMIO-programmed SRC/DST/LEN, one read then one write per word,
// releasing the bus (req low for a cycle) between every access so the arbitrator can re-grant.
module dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_a,
  input  logic [31:0] s_d,
  input  logic        s_we,
  input  logic        s_rd,
  output logic [31:0] s_spo,
  output logic        s_ready,
  output logic        req,
  input  logic        gnt,
  output logic [31:0] a,
  output logic [31:0] d,
  output logic        we,
  output logic        rd,
  input  logic [31:0] spo,
  input  logic        ready,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, RREQ, RSTB, RWAIT, WREQ, WSTB, WWAIT, REL} state_t;

  state_t           state, state_n;
  logic [31:0]      src, dst, rptr, wptr, data_buf;
  logic [LEN_W-1:0] len, cnt;
  logic             ie, done, aborted, wr_phase, abort_pend;
  logic             busy, ctrl_wr, start_cmd, abort_cmd, abort_any, zero_start;
  logic             rd_done, wr_done, to_done, to_abort;
  logic [1:0]       sel;
  logic             unused_addr_bits;

  assign sel              = s_a[3:2];
  assign unused_addr_bits = ^{s_a[31:4], s_a[1:0]};
  assign busy             = (state != IDLE);
  assign ctrl_wr          = s_we && (sel == 2'd3);
  assign start_cmd        = ctrl_wr && s_d[0];
  assign abort_cmd        = ctrl_wr && s_d[3];
  assign abort_any        = abort_pend || (busy && abort_cmd);
  assign zero_start       = start_cmd && (state == IDLE) && (len == '0);

  assign s_ready = s_we | s_rd;
  assign irq     = done & ie;
  // wr_phase flips on the read ready, so REL after a read already presents the write pointer
  assign a       = (state == IDLE) ? 32'd0 : (wr_phase ? wptr : rptr);
  assign d       = (state == IDLE) ? 32'd0 : data_buf;

  always_comb begin
    s_spo = 32'd0;
    if (s_rd) begin
      case (sel)
        2'd0:    s_spo = src;
        2'd1:    s_spo = dst;
        2'd2:    s_spo = 32'(len);
        default: s_spo = {28'd0, aborted, ie, done, busy};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    req      = 1'b0;
    rd       = 1'b0;
    we       = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    to_done  = 1'b0;
    to_abort = 1'b0;
    case (state)
      IDLE: begin
        if (start_cmd && (len != '0)) state_n = RREQ;
      end
      RREQ, WREQ: begin
        req = 1'b1;
        if (abort_any) begin
          state_n  = IDLE;
          to_abort = 1'b1;
        end else if (gnt) begin
          state_n = (state == RREQ) ? RSTB : WSTB;
        end
      end
      RSTB, RWAIT, WSTB, WWAIT: begin
        req = 1'b1;
        rd  = (state == RSTB);
        we  = (state == WSTB);
        // an issued strobe is always carried through to ready, abort or not
        if (ready) begin
          rd_done = (state == RSTB) || (state == RWAIT);
          wr_done = (state == WSTB) || (state == WWAIT);
          if (abort_any) begin
            state_n  = IDLE;
            to_abort = 1'b1;
          end else begin
            state_n = REL;
          end
        end else if (state == RSTB) begin
          state_n = RWAIT;
        end else if (state == WSTB) begin
          state_n = WWAIT;
        end
      end
      REL: begin
        if (abort_any) begin
          state_n  = IDLE;
          to_abort = 1'b1;
        end else if (wr_phase) begin
          state_n = WREQ;
        end else if (cnt != '0) begin
          state_n = RREQ;
        end else begin
          state_n = IDLE;
          to_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src        <= 32'd0;
      dst        <= 32'd0;
      len        <= '0;
      rptr       <= 32'd0;
      wptr       <= 32'd0;
      cnt        <= '0;
      data_buf   <= 32'd0;
      ie         <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      wr_phase   <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (s_we && !busy) begin
        case (sel)
          2'd0:    src <= s_d;
          2'd1:    dst <= s_d;
          2'd2:    len <= s_d[LEN_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        ie <= s_d[2];
        if (s_d[1]) done    <= 1'b0;
        if (s_d[3]) aborted <= 1'b0;
      end
      // set events come last so they win over a same-cycle clear
      if (to_done || zero_start) done    <= 1'b1;
      if (to_abort)              aborted <= 1'b1;

      if ((state == IDLE) && (state_n == RREQ)) begin
        rptr     <= src;
        wptr     <= dst;
        cnt      <= len;
        wr_phase <= 1'b0;
      end
      if (rd_done) begin
        data_buf <= spo;
        wr_phase <= 1'b1;
      end
      if (wr_done) begin
        rptr     <= rptr + 32'd4;
        wptr     <= wptr + 32'd4;
        cnt      <= cnt - {{(LEN_W-1){1'b0}}, 1'b1};
        wr_phase <= 1'b0;
      end

      if (busy && abort_cmd) abort_pend <= 1'b1;
      if (state_n == IDLE)   abort_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboarded bench for dma_copy: random memory contents, a bus-slave model with programmable
// ready delay, and a monitor that pops expected read addresses / write (addr,data) pairs.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_a = 32'd0, s_d = 32'd0;
  logic        s_we = 1'b0, s_rd = 1'b0;
  logic [31:0] s_spo;
  logic        s_ready;
  logic        req, we, rd, irq;
  logic        gnt = 1'b1;
  logic [31:0] a, d;
  logic [31:0] spo = 32'd0;
  logic        ready = 1'b0;

  always #5 clk = ~clk;

  dma_copy #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
    .req(req), .gnt(gnt), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
    .irq(irq)
  );

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, we_cnt = 0, req_cnt = 0;
  int rdy_dly = 1;
  bit slave_kill = 1'b0;
  bit slave_busy = 1'b0;
  bit pend_rel = 1'b0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd [$];
  logic [63:0] exp_wr [$];

  logic        sl_w;
  logic [31:0] sl_a, sl_d;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // bus slave: captures the strobe, waits rdy_dly cycles, then gives one ready cycle
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && (rd || we)) begin
        slave_busy = 1'b1;
        sl_w = we;
        sl_a = a;
        sl_d = d;
        repeat (rdy_dly) begin @(posedge clk); #1; end
        ready = 1'b1;
        if (!sl_w) spo = mem.exists(sl_a) ? mem[sl_a] : 32'd0;
        else if (!slave_kill) mem[sl_a] = sl_d;
        @(posedge clk); #1;
        ready = 1'b0;
        spo = 32'd0;
        slave_busy = 1'b0;
      end
    end
  end

  // monitor: scoreboard pops and the req-drop after every completed access
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_rel = 1'b0;
      end else begin
        if (pend_rel) check1("req_low_after_ready", req, 1'b0);
        pend_rel = ready && req;
        if (req) req_cnt++;
        if (rd) begin
          rd_cnt++;
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: addr %h with no read expected", a);
          end else begin
            check("read_addr", a, exp_rd.pop_front());
          end
        end
        if (we) begin
          we_cnt++;
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %h data %h with no write expected", a, d);
          end else begin
            e = exp_wr.pop_front();
            check("write_addr", a, e[63:32]);
            check("write_data", d, e[31:0]);
          end
        end
      end
    end
  end

  task automatic mmio_wr(logic [31:0] addr, logic [31:0] data);
    s_a = addr; s_d = data; s_we = 1'b1;
    @(posedge clk); #1;
    s_we = 1'b0;
  endtask

  task automatic mmio_rd(logic [31:0] addr, output logic [31:0] val);
    s_a = addr; s_rd = 1'b1;
    #1;
    val = s_spo;
    s_rd = 1'b0;
  endtask

  task automatic reg_check(string name, logic [31:0] addr, logic [31:0] exp);
    logic [31:0] v;
    mmio_rd(addr, v);
    check(name, v, exp);
  endtask

  task automatic wait_idle(string name, int budget);
    logic [31:0] v;
    int n;
    n = 0;
    mmio_rd(32'hC, v);
    while (v[0] && n < budget) begin
      @(posedge clk); #1;
      n++;
      mmio_rd(32'hC, v);
    end
    check1(name, v[0], 1'b0);
  endtask

  // queue a copy in the reference model: one read per source word, one write per dest word
  task automatic plan_copy(logic [31:0] sa, logic [31:0] da, int n, int n_writes);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ra;
      ra = sa + 32'(4 * i);
      if (!mem.exists(ra)) mem[ra] = $urandom;
      exp_rd.push_back(ra);
      if (i < n_writes) exp_wr.push_back({da + 32'(4 * i), mem[ra]});
    end
  endtask

  initial begin
    logic [31:0] v;
    int r0, w0, q0, n;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check1("rst_req", req, 1'b0);
    check1("rst_rd", rd, 1'b0);
    check1("rst_we", we, 1'b0);
    check("rst_a", a, 32'd0);
    check("rst_d", d, 32'd0);
    check1("rst_irq", irq, 1'b0);
    check1("s_ready_idle", s_ready, 1'b0);
    reg_check("rst_src", 32'h0, 32'd0);
    reg_check("rst_dst", 32'h4, 32'd0);
    reg_check("rst_len", 32'h8, 32'd0);
    reg_check("rst_ctrl", 32'hC, 32'd0);
    s_a = 32'h0; s_rd = 1'b1; #1;
    check1("s_ready_rd", s_ready, 1'b1);
    s_rd = 1'b0; #1;
    check("s_spo_no_rd", s_spo, 32'd0);

    // ---- three-word copy with irq
    plan_copy(32'h1000, 32'h2000, 3, 3);
    mmio_wr(32'h0, 32'h1000);
    mmio_wr(32'h4, 32'h2000);
    mmio_wr(32'h8, 32'h0003_0003);
    reg_check("len_trunc", 32'h8, 32'd3);
    mmio_wr(32'hC, 32'h5);
    reg_check("ctrl_busy", 32'hC, 32'h5);
    mmio_wr(32'h0, 32'hDEAD_0000);
    reg_check("src_locked_busy", 32'h0, 32'h1000);
    wait_idle("copy3_idle", 200);
    reg_check("copy3_ctrl", 32'hC, 32'h6);
    check1("copy3_irq", irq, 1'b1);
    for (int i = 0; i < 3; i++)
      check("copy3_mem", mem[32'h2000 + 32'(4 * i)], mem[32'h1000 + 32'(4 * i)]);
    check("copy3_rd_left", 32'(exp_rd.size()), 32'd0);
    check("copy3_wr_left", 32'(exp_wr.size()), 32'd0);
    mmio_wr(32'hC, 32'h6);
    reg_check("done_cleared", 32'hC, 32'h4);
    check1("irq_cleared", irq, 1'b0);

    // ---- zero length: DONE next cycle, no bus traffic
    mmio_wr(32'h8, 32'd0);
    q0 = req_cnt;
    mmio_wr(32'hC, 32'h1);
    reg_check("zero_len_done", 32'hC, 32'h2);
    repeat (5) @(posedge clk);
    #1 check("zero_len_no_req", 32'(req_cnt - q0), 32'd0);
    mmio_wr(32'hC, 32'h2);

    // ---- grant withheld for 10 cycles
    gnt = 1'b0;
    plan_copy(32'h4000, 32'h5000, 1, 1);
    mmio_wr(32'h0, 32'h4000);
    mmio_wr(32'h4, 32'h5000);
    mmio_wr(32'h8, 32'd1);
    r0 = rd_cnt;
    mmio_wr(32'hC, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check1("nognt_req", req, 1'b1);
    check("nognt_no_rd", 32'(rd_cnt - r0), 32'd0);
    gnt = 1'b1;
    wait_idle("gnt_idle", 100);
    check("gnt_one_rd", 32'(rd_cnt - r0), 32'd1);
    check("gnt_mem", mem[32'h5000], mem[32'h4000]);
    reg_check("gnt_ctrl", 32'hC, 32'h2);
    mmio_wr(32'hC, 32'h2);

    // ---- abort during a slow read
    rdy_dly = 5;
    plan_copy(32'h6000, 32'h7000, 1, 0);
    mmio_wr(32'h0, 32'h6000);
    mmio_wr(32'h4, 32'h7000);
    mmio_wr(32'h8, 32'd2);
    r0 = rd_cnt;
    w0 = we_cnt;
    mmio_wr(32'hC, 32'h1);
    n = 0;
    while (rd_cnt == r0 && n < 20) begin @(posedge clk); #1; n++; end
    check("abort_rd_seen", 32'(rd_cnt - r0), 32'd1);
    mmio_wr(32'hC, 32'h8);
    wait_idle("abort_idle", 100);
    reg_check("abort_ctrl", 32'hC, 32'h8);
    check("abort_no_write", 32'(we_cnt - w0), 32'd0);
    check("abort_rd_left", 32'(exp_rd.size()), 32'd0);
    mmio_wr(32'hC, 32'h8);
    reg_check("aborted_cleared", 32'hC, 32'h0);
    repeat (8) @(posedge clk);
    #1;

    // ---- source pointer wraps past 2^32
    rdy_dly = 1;
    plan_copy(32'hFFFF_FFFC, 32'h3000, 2, 2);
    mmio_wr(32'h0, 32'hFFFF_FFFC);
    mmio_wr(32'h4, 32'h3000);
    mmio_wr(32'h8, 32'd2);
    mmio_wr(32'hC, 32'h1);
    wait_idle("wrap_idle", 200);
    reg_check("wrap_ctrl", 32'hC, 32'h2);
    check("wrap_mem", mem[32'h3004], mem[32'h0]);
    mmio_wr(32'hC, 32'h2);

    // ---- reset while waiting for a write ready
    rdy_dly = 30;
    plan_copy(32'h1000, 32'h2000, 1, 1);
    mmio_wr(32'h0, 32'h1000);
    mmio_wr(32'h4, 32'h2000);
    mmio_wr(32'h8, 32'd2);
    w0 = we_cnt;
    mmio_wr(32'hC, 32'h5);
    n = 0;
    while (we_cnt == w0 && n < 60) begin @(posedge clk); #1; n++; end
    check("rst_mid_we_seen", 32'(we_cnt - w0), 32'd1);
    @(posedge clk); #1;
    slave_kill = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check1("midrst_req", req, 1'b0);
    check1("midrst_rd", rd, 1'b0);
    check1("midrst_we", we, 1'b0);
    check("midrst_a", a, 32'd0);
    check1("midrst_irq", irq, 1'b0);
    reg_check("midrst_src", 32'h0, 32'd0);
    reg_check("midrst_dst", 32'h4, 32'd0);
    reg_check("midrst_len", 32'h8, 32'd0);
    reg_check("midrst_ctrl", 32'hC, 32'd0);
    n = 0;
    while (slave_busy && n < 60) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check1("midrst_still_idle_req", req, 1'b0);
    check("final_rd_left", 32'(exp_rd.size()), 32'd0);
    check("final_wr_left", 32'(exp_wr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
